// File: rtl/envelope_slicer.sv
// envelope_slicer: rectifies a signed sample stream, accumulates it over each
// trigger-delimited period and slices the period mean into a bit with
// hysteresis. The mean is compared by cross-multiplication, so no divider is
// needed. Two-stage pipeline from closing edge to bit_valid_out.
module envelope_slicer #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 32,
    parameter int unsigned THRESH_HI   = 5000,
    parameter int unsigned THRESH_LO   = 5000,
    parameter int unsigned MIN_COUNT   = 1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   data_valid_in,
    input  logic                   period_trigger_in,
    input  logic                   clear_in,
    output logic                   bit_out,
    output logic                   bit_valid_out,
    output logic [COUNT_WIDTH-1:0] period_len_out,
    output logic                   short_period_out,
    output logic                   sat_out
);

    localparam int unsigned SUM_WIDTH = DATA_WIDTH + COUNT_WIDTH;

    localparam logic [SUM_WIDTH-1:0]   THRESH_HI_EXT = SUM_WIDTH'(THRESH_HI);
    localparam logic [SUM_WIDTH-1:0]   THRESH_LO_EXT = SUM_WIDTH'(THRESH_LO);
    localparam logic [SUM_WIDTH-1:0]   MIN_COUNT_EXT = SUM_WIDTH'(MIN_COUNT);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX     = '1;

    typedef enum logic [0:0] {StArm, StRun} state_t;

    state_t state_q, state_d;

    logic                   trig_prev_q;
    logic                   trig_edge;
    logic                   close_period;
    logic [DATA_WIDTH-1:0]  mag;

    logic [SUM_WIDTH-1:0]   sum_q, sum_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   sat_q, sat_d;

    logic                   snap_valid_q;
    logic [SUM_WIDTH-1:0]   snap_sum_q;
    logic [COUNT_WIDTH-1:0] snap_count_q;
    logic                   snap_sat_q;

    logic [SUM_WIDTH-1:0]   snap_count_ext;
    logic [SUM_WIDTH-1:0]   prod_hi;
    logic [SUM_WIDTH-1:0]   prod_lo;
    logic                   is_short;
    logic                   bit_next;
    logic                   emit;

    assign trig_edge = period_trigger_in & ~trig_prev_q;
    assign emit      = snap_valid_q & ~clear_in;

    // Magnitude as unsigned; the most-negative input maps to 2^(DATA_WIDTH-1).
    always_comb begin
        mag = data_in;
        if (data_in[DATA_WIDTH-1]) begin
            mag = ~data_in + DATA_WIDTH'(1);
        end
    end

    // Trigger history updates every cycle, clear or not.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            trig_prev_q <= 1'b0;
        end else begin
            trig_prev_q <= period_trigger_in;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StArm;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; clear beats a coincident edge, and the arming edge closes nothing.
    always_comb begin
        state_d      = state_q;
        close_period = 1'b0;
        if (clear_in) begin
            state_d = StArm;
        end else if (trig_edge) begin
            unique case (state_q)
                StArm: state_d = StRun;
                StRun: close_period = 1'b1;
                default: state_d = StArm;
            endcase
        end
    end

    // Accumulator next state; an edge-cycle sample opens the new period.
    always_comb begin
        sum_d   = sum_q;
        count_d = count_q;
        sat_d   = sat_q;
        if (clear_in) begin
            sum_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
        end else if (trig_edge) begin
            sum_d   = data_valid_in ? SUM_WIDTH'(mag) : '0;
            count_d = data_valid_in ? COUNT_WIDTH'(1) : '0;
            sat_d   = 1'b0;
        end else if (state_q == StArm) begin
            sum_d   = '0;
            count_d = '0;
            sat_d   = 1'b0;
        end else if (data_valid_in) begin
            if (count_q == COUNT_MAX) begin
                // Counter full: drop the sample, keep the sum consistent with count.
                sat_d = 1'b1;
            end else begin
                sum_d   = sum_q + SUM_WIDTH'(mag);
                count_d = count_q + COUNT_WIDTH'(1);
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sum_q   <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    // Stage 1: snapshot the closing period's totals.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            snap_valid_q <= 1'b0;
            snap_sum_q   <= '0;
            snap_count_q <= '0;
            snap_sat_q   <= 1'b0;
        end else begin
            snap_valid_q <= close_period;
            if (close_period) begin
                snap_sum_q   <= sum_q;
                snap_count_q <= count_q;
                snap_sat_q   <= sat_q;
            end
        end
    end

    // Decision: mean vs threshold as sum vs threshold*count.
    always_comb begin
        snap_count_ext = SUM_WIDTH'(snap_count_q);
        prod_hi        = THRESH_HI_EXT * snap_count_ext;
        prod_lo        = THRESH_LO_EXT * snap_count_ext;
        is_short       = snap_count_ext < MIN_COUNT_EXT;
        bit_next       = bit_out;
        if (!is_short) begin
            if (snap_sum_q > prod_hi) begin
                bit_next = 1'b1;
            end else if (snap_sum_q < prod_lo) begin
                bit_next = 1'b0;
            end
        end
    end

    // Stage 2: output registers, updated only on a decision cycle.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bit_out          <= 1'b0;
            bit_valid_out    <= 1'b0;
            period_len_out   <= '0;
            short_period_out <= 1'b0;
            sat_out          <= 1'b0;
        end else begin
            bit_valid_out <= emit;
            if (emit) begin
                bit_out          <= bit_next;
                period_len_out   <= snap_count_q;
                short_period_out <= is_short;
                sat_out          <= snap_sat_q;
            end
        end
    end

endmodule

// File: tb/tb_envelope_slicer.sv
// Directed bench for envelope_slicer: a wide-counter instance (a_*) and a
// 4-bit-counter instance (b_*) share the same stimulus.
module tb_envelope_slicer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [15:0] data_in = '0;
    logic        data_valid_in = 1'b0;
    logic        period_trigger_in = 1'b0;
    logic        clear_in = 1'b0;

    logic        a_bit, a_bv, a_short, a_sat;
    logic [15:0] a_len;
    logic        b_bit, b_bv, b_short, b_sat;
    logic [3:0]  b_len;

    int tests = 0;
    int fails = 0;
    int pcnt  = 0;
    int p0;

    always #5 clk_in = ~clk_in;

    envelope_slicer #(
        .DATA_WIDTH(16), .COUNT_WIDTH(16), .THRESH_HI(5000), .THRESH_LO(3000), .MIN_COUNT(4)
    ) dut_a (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .data_valid_in(data_valid_in),
        .period_trigger_in(period_trigger_in), .clear_in(clear_in), .bit_out(a_bit),
        .bit_valid_out(a_bv), .period_len_out(a_len), .short_period_out(a_short),
        .sat_out(a_sat)
    );

    envelope_slicer #(
        .DATA_WIDTH(16), .COUNT_WIDTH(4), .THRESH_HI(5000), .THRESH_LO(3000), .MIN_COUNT(4)
    ) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .data_valid_in(data_valid_in),
        .period_trigger_in(period_trigger_in), .clear_in(clear_in), .bit_out(b_bit),
        .bit_valid_out(b_bv), .period_len_out(b_len), .short_period_out(b_short),
        .sat_out(b_sat)
    );

    // Count decision pulses of instance a.
    always @(negedge clk_in) begin
        if (a_bv === 1'b1) pcnt++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        period_trigger_in = 1'b0;
        data_valid_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_edge();
        period_trigger_in = 1'b1;
        data_valid_in = 1'b0;
        tick();
        period_trigger_in = 1'b0;
    endtask

    task automatic feed(input int n, input int amp, input bit alt);
        for (int i = 0; i < n; i++) begin
            data_valid_in = 1'b1;
            data_in = (alt && i[0]) ? 16'(-amp) : 16'(amp);
            tick();
        end
        data_valid_in = 1'b0;
    endtask

    // Close the period with an edge; pulse must appear exactly 2 cycles later.
    task automatic close_check(input string tag, input logic b, input int len,
                               input logic sh, input logic sat);
        pulse_edge();
        chk({tag, "_lat1"}, 32'(a_bv), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(a_bv), 32'd1);
        chk({tag, "_bit"}, 32'(a_bit), 32'(b));
        chk({tag, "_len"}, 32'(a_len), 32'(len));
        chk({tag, "_short"}, 32'(a_short), 32'(sh));
        chk({tag, "_sat"}, 32'(a_sat), 32'(sat));
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_bit", 32'(a_bit), 0);
        chk("rst_valid", 32'(a_bv), 0);
        chk("rst_len", 32'(a_len), 0);
        chk("rst_short", 32'(a_short), 0);
        chk("rst_sat", 32'(a_sat), 0);
        rst_in = 1'b0;

        // Data before the arming edge is discarded; arming edge emits nothing
        feed(7, 9000, 1'b0);
        pulse_edge();
        idle(4);
        chk("arm_no_pulse", 32'(pcnt), 0);

        // Main function and hysteresis
        feed(100, 6000, 1'b1);
        close_check("amp6000", 1'b1, 100, 1'b0, 1'b0);
        feed(100, 4000, 1'b1);
        close_check("amp4000_band", 1'b1, 100, 1'b0, 1'b0);
        feed(100, 1000, 1'b1);
        close_check("amp1000", 1'b0, 100, 1'b0, 1'b0);
        feed(50, -32768, 1'b0);
        close_check("most_neg", 1'b1, 50, 1'b0, 1'b0);

        // Half the cycles invalid: 20 valid samples of 500
        for (int i = 0; i < 40; i++) begin
            data_valid_in = ~i[0];
            data_in = 16'd500;
            tick();
        end
        data_valid_in = 1'b0;
        close_check("half_valid", 1'b0, 20, 1'b0, 1'b0);
        feed(10, 6000, 1'b0);
        close_check("relatch1", 1'b1, 10, 1'b0, 1'b0);

        // Edges two cycles apart: short periods, bit held
        period_trigger_in = 1'b1;
        data_valid_in = 1'b0;
        tick();
        period_trigger_in = 1'b0;
        data_valid_in = 1'b1;
        data_in = 16'd6000;
        tick();
        chk("short0_valid", 32'(a_bv), 1);
        chk("short0_short", 32'(a_short), 1);
        chk("short0_len", 32'(a_len), 0);
        chk("short0_bit", 32'(a_bit), 1);
        period_trigger_in = 1'b1;
        tick();
        chk("short_gap", 32'(a_bv), 0);
        period_trigger_in = 1'b0;
        data_valid_in = 1'b0;
        tick();
        chk("short1_valid", 32'(a_bv), 1);
        chk("short1_short", 32'(a_short), 1);
        chk("short1_len", 32'(a_len), 1);
        chk("short1_bit", 32'(a_bit), 1);

        // Back-to-back edges at the minimum spacing: one pulse each
        idle(2);
        p0 = pcnt;
        for (int i = 0; i < 4; i++) begin
            period_trigger_in = 1'b1;
            tick();
            period_trigger_in = 1'b0;
            tick();
        end
        idle(3);
        chk("b2b_pulses", 32'(pcnt - p0), 4);
        chk("b2b_bit", 32'(a_bit), 1);

        // Asynchronous reset mid-period
        feed(10, 6000, 1'b0);
        data_valid_in = 1'b1;
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_bit", 32'(a_bit), 0);
        chk("arst_short", 32'(a_short), 0);
        chk("arst_len", 32'(a_len), 0);
        rst_in = 1'b0;
        data_valid_in = 1'b0;
        tick();
        p0 = pcnt;
        pulse_edge();
        idle(4);
        chk("arst_arm_no_pulse", 32'(pcnt - p0), 0);
        feed(10, 6000, 1'b0);
        close_check("arst_after", 1'b1, 10, 1'b0, 1'b0);

        // Clear coincident with an edge: bit and flags held, edge not an arming edge
        idle(2);
        feed(10, 100, 1'b0);
        period_trigger_in = 1'b1;
        clear_in = 1'b1;
        tick();
        period_trigger_in = 1'b0;
        clear_in = 1'b0;
        p0 = pcnt;
        feed(5, 6000, 1'b0);
        idle(4);
        chk("clr_no_pulse", 32'(pcnt - p0), 0);
        chk("clr_bit_hold", 32'(a_bit), 1);
        chk("clr_len_hold", 32'(a_len), 10);
        pulse_edge();
        idle(4);
        chk("clr_arm_no_pulse", 32'(pcnt - p0), 0);
        feed(8, 500, 1'b0);
        close_check("clr_after", 1'b0, 8, 1'b0, 1'b0);

        // Counter saturation on the 4-bit instance
        idle(2);
        feed(20, 6000, 1'b0);
        close_check("wide_20", 1'b1, 20, 1'b0, 1'b0);
        chk("sat_valid", 32'(b_bv), 1);
        chk("sat_len", 32'(b_len), 15);
        chk("sat_flag", 32'(b_sat), 1);
        chk("sat_bit", 32'(b_bit), 1);
        chk("sat_short", 32'(b_short), 0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/envelope_slicer.md
Name: envelope_slicer

Overview:
- Parametrised successor to the single-threshold period averager. It rectifies a signed sample stream and accumulates it over each period, delimited by rising edges of a trigger. At each period boundary it slices the period mean into a bit using hysteresis thresholds.
- No divider: the mean is compared by cross-multiplication.
- Adds sample-valid gating, a first-period discard, short-period and saturation flags, and a valid strobe.
- Sits between the demodulation filter and the bit decoder in the receive path.

Parameters:
- DATA_WIDTH, 32: width of signed input sample.
- COUNT_WIDTH, 32: width of per-period sample counter; the counter saturates.
- THRESH_HI, 5000: mean strictly above this sets the bit to 1.
- THRESH_LO, 5000: mean strictly below this clears the bit to 0. THRESH_LO <= THRESH_HI is required; equal values give a plain slicer.
- MIN_COUNT, 1: periods with fewer samples than this produce no decision. Must be >= 1.

Ports:
- clk_in, input, 1: clock. Single clock domain.
- rst_in, input, 1: reset, asynchronous, active-high.
- data_in, input, DATA_WIDTH: signed sample.
- data_valid_in, input, 1: sample qualifier.
- period_trigger_in, input, 1: period marker, level; the rising edge is used.
- clear_in, input, 1: synchronous soft clear.
- bit_out, output, 1: sliced bit, held between decisions.
- bit_valid_out, output, 1: one-cycle pulse per completed period.
- period_len_out, output, COUNT_WIDTH: sample count of the last completed period. Valid with bit_valid_out.
- short_period_out, output, 1: with bit_valid_out, count < MIN_COUNT; bit_out was held.
- sat_out, output, 1: with bit_valid_out, the counter saturated during the period.

Behaviour:
- Reset: asynchronous, active-high. All outputs, accumulators, pipeline registers and trigger history go to 0. FSM goes to ARM.
- Rectify: |data_in| as an unsigned DATA_WIDTH value. The most-negative input maps to 2^(DATA_WIDTH-1) with no wrap.
- Edge detect: edge = period_trigger_in & ~trig_prev. trig_prev updates every cycle, including in ARM.
- Sample acceptance: a sample is accepted when data_valid_in = 1.
  - A sample on an edge cycle belongs to the NEW period: sum <= |x|, count <= 1.
  - A non-valid sample on an edge cycle gives sum <= 0, count <= 0.
- Accumulator: sum is DATA_WIDTH+COUNT_WIDTH bits wide. count saturates at 2^COUNT_WIDTH-1.
  - Once saturated, further samples are ignored (sum frozen) and the period's sat flag is set.
  - The sum cannot overflow.
- FSM:
  - ARM: wait for the first edge after reset or clear. That edge starts a period, emits nothing, and moves to RUN. Data before it is discarded.
  - RUN: every edge closes the current period and starts the next.
- Pipeline (fully pipelined, no stall; edges on consecutive cycles are legal):
  - Stage 1 (edge cycle +1): snapshot sum, count and sat.
  - Stage 2 (edge cycle +2): compute decision and register outputs; bit_valid_out pulses here.
  - Latency from closing edge to bit_valid_out is 2 cycles.
- Decision at stage 2, with products THRESH*count at DATA_WIDTH+COUNT_WIDTH bits, compared unsigned:
  - count < MIN_COUNT: short_period_out = 1 and bit_out holds.
  - else if sum > THRESH_HI*count: bit_out = 1.
  - else if sum < THRESH_LO*count: bit_out = 0.
  - else: bit_out holds (hysteresis band).
- Output registers:
  - period_len_out, short_period_out and sat_out update only on a bit_valid_out cycle and hold otherwise.
  - bit_valid_out is 0 on all other cycles.
- clear_in = 1 (synchronous):
  - Effect: FSM to ARM, accumulators to 0, in-flight pipeline stages squashed (no pulse).
  - bit_out keeps its value; flags keep their values.
  - Priority: clear_in has priority over a simultaneous edge; that edge is not used as the arming edge.
- Reset mid-period: everything returns to reset values immediately. The next period needs a fresh arming edge.

Test Plan:
- DATA_WIDTH=16, COUNT_WIDTH=16, HI=5000, LO=3000, MIN_COUNT=4. After reset: edge, then 100 valid samples alternating +6000/-6000, then edge -> bit_valid_out 2 cycles after the edge, bit_out=1, period_len_out=100, short=0, sat=0. The first (arming) edge gives no pulse.
- Same bench, next periods at amplitude 4000, then 1000 -> first pulse bit_out=1 (held in band), second pulse bit_out=0.
- Period of 50 samples of -32768 -> bit_out=1, no wrap. Then a period with data_valid_in low on half the cycles -> period_len_out equals the valid-sample count.
- Edges 2 cycles apart after a bit_out=1 decision -> pulse with short_period_out=1, period_len_out<=2, bit_out stays 1. Edges on consecutive cycles -> one pulse per edge.
- COUNT_WIDTH=4, 20 valid samples of 6000 in one period -> period_len_out=15, sat_out=1, bit_out=1.
- Assert rst_in asynchronously mid-period, and separately clear_in coincident with an edge -> outputs 0 (reset) or bit held (clear). No pulse until the second subsequent edge.
